// File: rtl/word_count_accum.sv
// word_count_accum
//   Per-entry word-count table fed by the search/add stage's accumulate stream.
//   Each table entry holds {valid, key value, count}. Each accepted update adds
//   its increment to the count of its entry. The count saturates at all ones.
//   On request, the block scans the whole table and emits every valid entry as
//   a ready/valid stream so the host can read it back.
//
// Build option
//   WCA_CLEAR_ON_READ_EN : when defined, each drained entry is zeroed as its
//                          transfer completes, so a drain empties the table.
//                          When undefined, a drain does not change the table.
//
// Ports
//   clk, reset      clock; synchronous active-high reset (the FSM starts in CLEAR)
//   accum_addr      entry address; bits above ADDR_W must be zero
//   accum_din       [63:32] key value, [31:0] increment
//   accum_we        update strobe; there is no backpressure upstream
//   clear, drain    command pulses; they are acted on only in IDLE
//   busy            high in CLEAR/DRAIN or while an update is in flight
//   drop_err        sticky; an update was lost. Cleared by reset or clear
//   out_valid/out_ready/out_addr/out_value/out_count   drain stream
//   drain_done      one-cycle pulse when a drain has finished
//
// States
//   state    | meaning
//   ST_CLEAR | zeroing entries 0..DEPTH-1, one per cycle
//   ST_IDLE  | accepting updates and commands
//   ST_DRAIN | scanning the table and emitting valid entries
module word_count_accum #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       accum_addr,
  input  logic [63:0]       accum_din,
  input  logic              accum_we,
  input  logic              clear,
  input  logic              drain,
  output logic              busy,
  output logic              drop_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_value,
  output logic [CNT_W-1:0]  out_count,
  output logic              drain_done
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_DRAIN} state_t;

  state_t r_state, w_state_nxt;

  logic             r_tbl_vld [DEPTH];
  logic [31:0]      r_tbl_val [DEPTH];
  logic [CNT_W-1:0] r_tbl_cnt [DEPTH];

  logic              r_s1_vld;
  logic [ADDR_W-1:0] r_s1_addr;
  logic [31:0]       r_s1_val;
  logic [CNT_W-1:0]  r_s1_inc;
  logic [CNT_W-1:0]  r_s1_old;

  logic [ADDR_W-1:0] r_clr_addr;
  logic [ADDR_W-1:0] r_scan_addr;
  logic              r_scan_done;
  logic              r_drain_pend;
  logic              r_drop_err;
  logic              r_drain_done;
  logic              r_out_valid;
  logic [ADDR_W-1:0] r_out_addr;
  logic [31:0]       r_out_value;
  logic [CNT_W-1:0]  r_out_count;

  logic              w_addr_ok;
  logic              w_accept;
  logic              w_drop;
  logic              w_go_clear;
  logic              w_scan_adv;
  logic [ADDR_W-1:0] w_in_addr;
  logic [CNT_W:0]    w_s2_sum;
  logic [CNT_W-1:0]  w_s2_cnt;

  logic              w_wr_en;
  logic [ADDR_W-1:0] w_wr_addr;
  logic              w_wr_vld;
  logic [31:0]       w_wr_val;
  logic [CNT_W-1:0]  w_wr_cnt;

  assign w_in_addr  = accum_addr[ADDR_W-1:0];
  assign w_addr_ok  = (accum_addr[31:ADDR_W] == '0);
  assign w_accept   = accum_we && (r_state == ST_IDLE) && w_addr_ok;
  assign w_drop     = accum_we && ((r_state != ST_IDLE) || !w_addr_ok);
  assign w_go_clear = (r_state == ST_IDLE) && clear;

  // A new scan read may be issued when the output slot is empty or is being
  // emptied in this cycle.
  assign w_scan_adv = (r_state == ST_DRAIN) && !r_scan_done && (!r_out_valid || out_ready);

  // S2: saturating add using one extra carry bit.
  assign w_s2_sum = {1'b0, r_s1_old} + {1'b0, r_s1_inc};
  assign w_s2_cnt = w_s2_sum[CNT_W] ? '1 : w_s2_sum[CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_CLEAR;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CLEAR: if (r_clr_addr == ADDR_W'(DEPTH - 1)) w_state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (clear)
          w_state_nxt = ST_CLEAR;
        // Leave for DRAIN only when no update is in flight and none is
        // arriving, so the scan never races a pending table write.
        else if ((drain || r_drain_pend) && !r_s1_vld && !w_accept)
          w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: if (r_scan_done && (!r_out_valid || out_ready)) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_CLEAR;
    endcase
  end

  // S1: register the update and read the old count. A same-address update in
  // S2 writes the table on this same edge, so its result is forwarded.
  // A distance-2 update has already been written and is read directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_vld  <= 1'b0;
      r_s1_addr <= '0;
      r_s1_val  <= '0;
      r_s1_inc  <= '0;
      r_s1_old  <= '0;
    end else begin
      r_s1_vld <= w_accept && !w_go_clear;
      if (w_accept) begin
        r_s1_addr <= w_in_addr;
        r_s1_val  <= accum_din[63:32];
        r_s1_inc  <= CNT_W'(accum_din[31:0]);
        r_s1_old  <= (r_s1_vld && (r_s1_addr == w_in_addr)) ? w_s2_cnt : r_tbl_cnt[w_in_addr];
      end
    end
  end

  // The table has one write port. Its sources never overlap: CLEAR accepts no
  // updates, and DRAIN is entered only with the pipeline empty.
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_addr = r_s1_addr;
    w_wr_vld  = 1'b0;
    w_wr_val  = '0;
    w_wr_cnt  = '0;
    if (r_state == ST_CLEAR) begin
      w_wr_en   = 1'b1;
      w_wr_addr = r_clr_addr;
    end else if (r_s1_vld) begin
      w_wr_en  = 1'b1;
      w_wr_vld = 1'b1;
      w_wr_val = r_s1_val;
      w_wr_cnt = w_s2_cnt;
    end
`ifdef WCA_CLEAR_ON_READ_EN
    else if ((r_state == ST_DRAIN) && r_out_valid && out_ready) begin
      w_wr_en   = 1'b1;
      w_wr_addr = r_out_addr;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset && w_wr_en) begin
      r_tbl_vld[w_wr_addr] <= w_wr_vld;
      r_tbl_val[w_wr_addr] <= w_wr_val;
      r_tbl_cnt[w_wr_addr] <= w_wr_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_clr_addr   <= '0;
      r_drain_pend <= 1'b0;
      r_drop_err   <= 1'b0;
      r_drain_done <= 1'b0;
      r_scan_addr  <= '0;
      r_scan_done  <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_addr   <= '0;
      r_out_value  <= '0;
      r_out_count  <= '0;
    end else begin
      r_clr_addr   <= (r_state == ST_CLEAR) ? r_clr_addr + 1'b1 : '0;
      r_drain_pend <= (r_state == ST_IDLE) && (w_state_nxt == ST_IDLE) && (drain || r_drain_pend);
      r_drain_done <= (r_state == ST_DRAIN) && (w_state_nxt == ST_IDLE);

      if (w_go_clear)  r_drop_err <= 1'b0;
      else if (w_drop) r_drop_err <= 1'b1;

      if (r_state != ST_DRAIN) begin
        r_scan_addr <= '0;
        r_scan_done <= 1'b0;
        r_out_valid <= 1'b0;
      end else if (w_scan_adv) begin
        r_out_valid <= r_tbl_vld[r_scan_addr];
        r_out_addr  <= r_scan_addr;
        r_out_value <= r_tbl_val[r_scan_addr];
        r_out_count <= r_tbl_cnt[r_scan_addr];
        r_scan_addr <= r_scan_addr + 1'b1;
        if (r_scan_addr == '1) r_scan_done <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign busy       = (r_state != ST_IDLE) || r_s1_vld;
  assign drop_err   = r_drop_err;
  assign out_valid  = r_out_valid;
  assign out_addr   = r_out_addr;
  assign out_value  = r_out_value;
  assign out_count  = r_out_count;
  assign drain_done = r_drain_done;

endmodule

// File: tb/tb_word_count_accum.sv
// Testbench for word_count_accum. A reference table is updated with plain
// saturating arithmetic whenever an update is issued. A drain request pushes
// the valid entries, in ascending address order, into a queue. A monitor
// compares each handshake transfer against that queue.
module tb_word_count_accum;
  localparam int ADDR_W = 10;
  localparam int CNT_W  = 32;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [31:0]       accum_addr = '0;
  logic [63:0]       accum_din = '0;
  logic              accum_we = 1'b0;
  logic              clear = 1'b0;
  logic              drain = 1'b0;
  logic              busy;
  logic              drop_err;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [ADDR_W-1:0] out_addr;
  logic [31:0]       out_value;
  logic [CNT_W-1:0]  out_count;
  logic              drain_done;

  word_count_accum #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .accum_addr(accum_addr), .accum_din(accum_din),
    .accum_we(accum_we), .clear(clear), .drain(drain), .busy(busy),
    .drop_err(drop_err), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_value(out_value), .out_count(out_count),
    .drain_done(drain_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       value;
    logic [31:0]       count;
  } exp_t;

  exp_t        exp_q[$];
  bit          m_vld [DEPTH];
  logic [31:0] m_val [DEPTH];
  logic [31:0] m_cnt [DEPTH];

  int n_checks = 0;
  int n_pass   = 0;
  int n_done   = 0;
  int done_base;
  int rdy_mode = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int a = 0; a < DEPTH; a++) begin
      m_vld[a] = 1'b0;
      m_val[a] = '0;
      m_cnt[a] = '0;
    end
  endtask

  task automatic model_upd(input int a, input logic [31:0] v, input logic [31:0] inc);
    longint unsigned s;
    s = longint'(m_cnt[a]) + longint'(inc);
    m_cnt[a] = (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
    m_val[a] = v;
    m_vld[a] = 1'b1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] v, input logic [31:0] inc, input bit apply);
    accum_addr = a;
    accum_din  = {v, inc};
    accum_we   = 1'b1;
    tick();
    accum_we   = 1'b0;
    if (apply) model_upd(int'(a[ADDR_W-1:0]), v, inc);
  endtask

  task automatic start_drain();
    exp_t e;
    for (int a = 0; a < DEPTH; a++) begin
      if (m_vld[a]) begin
        e.addr  = ADDR_W'(a);
        e.value = m_val[a];
        e.count = m_cnt[a];
        exp_q.push_back(e);
      end
    end
    done_base = n_done;
    drain = 1'b1;
    tick();
    drain = 1'b0;
  endtask

  task automatic finish_drain(input int bound);
    for (int i = 0; i < bound && n_done == done_base; i++) tick();
    check("drain_done_count", 64'(n_done - done_base), 64'd1);
    check("entries_left_at_done", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
`ifdef WCA_CLEAR_ON_READ_EN
    model_clear();
`endif
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound && busy; i++) tick();
    check("idle_reached", 64'(busy), 64'd0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  bit                pend_prev = 1'b0;
  logic [ADDR_W-1:0] prev_addr;
  logic [31:0]       prev_value;
  logic [CNT_W-1:0]  prev_count;

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (pend_prev) begin
        check("hold_valid_count", {31'd0, out_valid, out_count}, {31'd0, 1'b1, prev_count});
        check("hold_addr_value", {22'd0, out_addr, out_value}, {22'd0, prev_addr, prev_value});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_entry: got addr %0d count 0x%0h, expected no entry", out_addr, out_count);
        end else begin
          e = exp_q.pop_front();
          check("drain_addr_count", {22'd0, out_addr, out_count}, {22'd0, e.addr, e.count});
          check("drain_value", {32'd0, out_value}, {32'd0, e.value});
        end
      end
      if (drain_done) begin
        n_done++;
        check("done_without_valid", 64'(out_valid), 64'd0);
      end
      pend_prev  = out_valid && !out_ready;
      prev_addr  = out_addr;
      prev_value = out_value;
      prev_count = out_count;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic [31:0] inc;
    bit          bad;

    model_clear();
    repeat (3) tick();
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_drop_err", 64'(drop_err), 64'd0);
    check("reset_drain_done", 64'(drain_done), 64'd0);
    check("reset_out_count", 64'(out_count), 64'd0);
    reset = 1'b0;
    repeat (DEPTH + 2) tick();
    check("busy_after_init_clear", 64'(busy), 64'd0);

    start_drain();
    finish_drain(DEPTH + 4);

    repeat (3) send(32'd5, 32'hAA, 32'd1, 1'b1);
    start_drain();
    finish_drain(3 * DEPTH);

    send(32'd7, 32'h70, 32'd1, 1'b1);
    send(32'd9, 32'h90, 32'd1, 1'b1);
    send(32'd7, 32'h71, 32'd1, 1'b1);
    start_drain();
    finish_drain(3 * DEPTH);

    send(32'd3, 32'h33, 32'hFFFF_FFFE, 1'b1);
    send(32'd3, 32'h34, 32'd5, 1'b1);
    start_drain();
    finish_drain(3 * DEPTH);

    send(32'h0001_0000, 32'hDEAD, 32'd9, 1'b0);
    check("drop_err_bad_addr", 64'(drop_err), 64'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("drop_err_cleared", 64'(drop_err), 64'd0);
    model_clear();
    wait_idle(DEPTH + 4);

    send(32'd2, 32'h22, 32'd4, 1'b1);
    send(32'd12, 32'hC0, 32'd6, 1'b1);
    start_drain();
    repeat (5) tick();
    send(32'd2, 32'h55, 32'd100, 1'b0);
    check("drop_err_in_drain", 64'(drop_err), 64'd1);
    finish_drain(3 * DEPTH);
    start_drain();
    finish_drain(3 * DEPTH);

    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      a   = 32'($urandom_range(0, 15));
      bad = ($urandom_range(0, 15) == 0);
      inc = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, 100));
      send(bad ? (32'h400 | a) : a, 32'($urandom), inc, !bad);
      repeat ($urandom_range(0, 2)) tick();
    end
    rdy_mode = 1;
    start_drain();
    finish_drain(3 * DEPTH);
    rdy_mode = 2;
    start_drain();
    finish_drain(3 * DEPTH);
    rdy_mode = 0;

    repeat (4) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
